// File: rtl/line_buffer_sequencer_pkg.sv
// Shared definitions for the 3x3 filter front end: geometry defaults, the
// sequencer state encoding and the mod-4 line-buffer pointer increment.
package line_buffer_sequencer_pkg;

    localparam int DEF_IMG_WIDTH = 512;
    localparam int DEF_NUM_LB    = 4;
    localparam int DEF_CNT_W     = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_t;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/line_buffer_sequencer.sv
// Line-buffer sequencer: rotates pixel writes across the line buffers and,
// once three lines are held, strobes 3-row window reads and interrupts the host.
module line_buffer_sequencer
    import line_buffer_sequencer_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int NUM_LB    = DEF_NUM_LB,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              axis_clk,
    input  logic              axis_resetn,
    input  logic              i_datavalid,
    output logic              s_axis_ready,
    input  logic              m_axis_ready,
    output logic [NUM_LB-1:0] o_lb_wr_en,
    output logic [NUM_LB-1:0] o_lb_rd_en,
    output logic [1:0]        o_rd_sel,
    output logic              o_win_valid,
    output logic              intr,
    output logic              o_ovf
);

    localparam int               PIX_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_LB * IMG_WIDTH);
    localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(3 * IMG_WIDTH);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_WIDTH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_total_cnt;
    logic [PIX_W-1:0]  r_wr_cnt;
    logic [PIX_W-1:0]  r_rd_cnt;
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic              r_win_valid;
    logic              r_intr;
    logic              r_ovf;
    logic              w_acc;
    logic              w_rd;
    logic              w_wr_last;
    logic              w_rd_last;
    logic [NUM_LB-1:0] w_rd_en;

    assign s_axis_ready = (r_total_cnt < FULL_CNT);
    // Qualified with reset so no write enable leaks out while held in reset.
    assign w_acc        = i_datavalid & s_axis_ready & axis_resetn;
    assign w_wr_last    = w_acc && (r_wr_cnt == LAST_PIX);
    assign w_rd_last    = w_rd && (r_rd_cnt == LAST_PIX);
    assign o_lb_wr_en   = w_acc ? (NUM_LB'(1) << r_wr_ptr) : '0;

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (r_total_cnt >= WIN_CNT) w_next_state = RD;
            RD:      if (w_rd_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_rd    = (r_state == RD) & m_axis_ready;
        w_rd_en = '0;
        if (w_rd) begin
            w_rd_en = (NUM_LB'(1) << r_rd_ptr)
                    | (NUM_LB'(1) << ptr_inc(r_rd_ptr))
                    | (NUM_LB'(1) << ptr_inc(ptr_inc(r_rd_ptr)));
        end
    end

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_total_cnt <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_win_valid <= 1'b0;
            r_intr      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_acc) begin
                if (w_wr_last) begin
                    r_wr_cnt <= '0;
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end else begin
                    r_wr_cnt <= r_wr_cnt + PIX_W'(1);
                end
            end
            if (w_rd) begin
                if (w_rd_last) begin
                    r_rd_cnt <= '0;
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end else begin
                    r_rd_cnt <= r_rd_cnt + PIX_W'(1);
                end
            end
            // Each read strobe retires one pixel of the top row.
            if (w_acc && !w_rd) begin
                r_total_cnt <= r_total_cnt + CNT_W'(1);
            end else if (w_rd && !w_acc) begin
                r_total_cnt <= r_total_cnt - CNT_W'(1);
            end
            r_win_valid <= w_rd;
            r_intr      <= w_rd_last;
            if (i_datavalid && !s_axis_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_lb_rd_en  = w_rd_en;
    assign o_rd_sel    = r_rd_ptr;
    assign o_win_valid = r_win_valid;
    assign intr        = r_intr;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Directed bench for line_buffer_sequencer: fill, concurrent read, backpressure,
// overflow, pointer wrap and mid-read reset, checked with immediate assertions.
module tb_line_buffer_sequencer;

    localparam int W = 512;

    logic       axis_clk     = 1'b0;
    logic       axis_resetn  = 1'b0;
    logic       i_datavalid  = 1'b0;
    logic       m_axis_ready = 1'b0;
    logic       s_axis_ready;
    logic [3:0] o_lb_wr_en;
    logic [3:0] o_lb_rd_en;
    logic [1:0] o_rd_sel;
    logic       o_win_valid;
    logic       intr;
    logic       o_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    line_buffer_sequencer #(
        .IMG_WIDTH (512),
        .NUM_LB    (4),
        .CNT_W     (12)
    ) dut (
        .axis_clk     (axis_clk),
        .axis_resetn  (axis_resetn),
        .i_datavalid  (i_datavalid),
        .s_axis_ready (s_axis_ready),
        .m_axis_ready (m_axis_ready),
        .o_lb_wr_en   (o_lb_wr_en),
        .o_lb_rd_en   (o_lb_rd_en),
        .o_rd_sel     (o_rd_sel),
        .o_win_valid  (o_win_valid),
        .intr         (intr),
        .o_ovf        (o_ovf)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic tick(input logic dv, input logic mr);
        @(negedge axis_clk);
        i_datavalid  = dv;
        m_axis_ready = mr;
        #1;
    endtask

    task automatic rst_pulse();
        axis_resetn = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        axis_resetn = 1'b1;
    endtask

    function automatic logic [3:0] rot3(input int p);
        logic [7:0] t;
        t = 8'h77;
        t = t << p;
        return t[7:4];
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_intr;
        int n_str;
        int n_wv;
        int exp_str;
        int last_c;
        int n_win;
        int n_cur;
        logic prev_s;
        logic hit;

        // Reset holds every output quiet regardless of input activity
        axis_resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(i[0], i[1]);
            chk("rst_ready",   32'(s_axis_ready), 1);
            chk("rst_wr_en",   32'(o_lb_wr_en),   0);
            chk("rst_rd_en",   32'(o_lb_rd_en),   0);
            chk("rst_rd_sel",  32'(o_rd_sel),     0);
            chk("rst_win_val", 32'(o_win_valid),  0);
            chk("rst_intr",    32'(intr),         0);
            chk("rst_ovf",     32'(o_ovf),        0);
        end
        axis_resetn = 1'b1;

        // Three-line fill, then one full window read
        rst_pulse();
        for (int i = 0; i < 3*W; i++) begin
            tick(1'b1, 1'b1);
            chk("fill_wr_en", 32'(o_lb_wr_en), 1 << (i / W));
            chk("fill_rd_en", 32'(o_lb_rd_en), 0);
        end
        tick(1'b0, 1'b1);
        chk("fill_pre_rd", 32'(o_lb_rd_en), 0);
        for (int j = 0; j < W; j++) begin
            tick(1'b0, 1'b1);
            chk("fill_rd_en_win", 32'(o_lb_rd_en),  32'h7);
            chk("fill_win_lag",   32'(o_win_valid), 32'(j > 0));
            chk("fill_no_intr",   32'(intr),        0);
        end
        tick(1'b0, 1'b1);
        chk("fill_intr",       32'(intr),        1);
        chk("fill_rd_en_end",  32'(o_lb_rd_en),  0);
        chk("fill_win_last",   32'(o_win_valid), 1);
        chk("fill_rd_sel",     32'(o_rd_sel),    1);
        tick(1'b0, 1'b1);
        chk("fill_intr_pulse", 32'(intr),        0);
        chk("fill_win_off",    32'(o_win_valid), 0);

        // Four lines back-to-back with reads running concurrently
        rst_pulse();
        n_intr = 0;
        for (int i = 0; i < 4*W; i++) begin
            tick(1'b1, 1'b1);
            chk("four_ready", 32'(s_axis_ready), 1);
            chk("four_wr_en", 32'(o_lb_wr_en),   1 << (i / W));
            if (intr) n_intr++;
        end
        chk("four_no_early_intr", 32'(n_intr), 0);
        tick(1'b0, 1'b1);
        chk("four_last_strobe", 32'(o_lb_rd_en), 32'h7);
        tick(1'b0, 1'b1);
        chk("four_intr",   32'(intr),     1);
        chk("four_rd_sel", 32'(o_rd_sel), 1);
        tick(1'b1, 1'b1);
        chk("four_next_rd_en", 32'(o_lb_rd_en), 32'he);
        chk("four_wr_wrap",    32'(o_lb_wr_en), 1);
        // 1536 buffered: exactly 512 more pixels fit before ready drops
        for (int k = 0; k < W; k++) begin
            tick(1'b1, 1'b0);
            chk("four_room_ready", 32'(s_axis_ready), 1);
        end
        tick(1'b1, 1'b0);
        chk("four_full_ready", 32'(s_axis_ready), 0);
        chk("four_full_wr_en", 32'(o_lb_wr_en),   0);

        // Backpressure: m_axis_ready toggles every cycle during the read
        rst_pulse();
        for (int i = 0; i < 3*W; i++) tick(1'b1, 1'b0);
        n_str = 0; n_wv = 0; n_intr = 0; exp_str = 0; last_c = -10; prev_s = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            logic s;
            tick(1'b0, c[0]);
            s = (c >= 1) && c[0] && (exp_str < W);
            chk("bp_rd_en",     32'(o_lb_rd_en),  s ? 32'h7 : 32'h0);
            chk("bp_win_valid", 32'(o_win_valid), 32'(prev_s));
            chk("bp_intr",      32'(intr),        32'(c == last_c + 1));
            if (s) begin
                exp_str++;
                if (exp_str == W) last_c = c;
            end
            prev_s = s;
            if (o_lb_rd_en != 4'b0) n_str++;
            if (o_win_valid) n_wv++;
            if (intr) n_intr++;
        end
        chk("bp_strobe_count", 32'(n_str),  W);
        chk("bp_wv_count",     32'(n_wv),   W);
        chk("bp_intr_count",   32'(n_intr), 1);

        // Overflow with reads stalled
        rst_pulse();
        for (int i = 0; i < 4*W; i++) begin
            tick(1'b1, 1'b0);
            chk("ovf_ready", 32'(s_axis_ready), 1);
            chk("ovf_wr_en", 32'(o_lb_wr_en),   1 << (i / W));
        end
        tick(1'b1, 1'b0);
        chk("ovf_ready_drop", 32'(s_axis_ready), 0);
        chk("ovf_drop_wr_en", 32'(o_lb_wr_en),   0);
        chk("ovf_not_yet",    32'(o_ovf),        0);
        tick(1'b0, 1'b0);
        chk("ovf_set",        32'(o_ovf),        1);
        tick(1'b0, 1'b1);
        chk("ovf_rd_en",      32'(o_lb_rd_en),   32'h7);
        tick(1'b1, 1'b0);
        chk("ovf_ready_back", 32'(s_axis_ready), 1);
        chk("ovf_wr_ptr0",    32'(o_lb_wr_en),   1);
        chk("ovf_sticky",     32'(o_ovf),        1);

        // Six lines with reads enabled, then reset 200 strobes into window 4
        rst_pulse();
        n_win = 0; n_cur = 0; hit = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tick(c < 6*W, 1'b1);
            chk("wrap_ready", 32'(s_axis_ready), 1);
            if (c == 4*W) chk("wrap_wr_en_l5", 32'(o_lb_wr_en), 1);
            if (c == 5*W) chk("wrap_wr_en_l6", 32'(o_lb_wr_en), 2);
            if (o_lb_rd_en != 4'b0) begin
                chk("wrap_rd_en", 32'(o_lb_rd_en), 32'(rot3(n_win % 4)));
                n_cur++;
            end
            if (intr) begin
                n_win++;
                n_cur = 0;
            end
            chk("wrap_rd_sel", 32'(o_rd_sel), n_win % 4);
            if (n_win == 3 && n_cur == 200) begin
                hit = 1'b1;
                break;
            end
        end
        chk("wrap_reached_rd200", 32'(hit), 1);
        tick(1'b0, 1'b0);
        axis_resetn = 1'b0;
        #1;
        chk("mid_rst_rd_sel",  32'(o_rd_sel),     0);
        chk("mid_rst_ready",   32'(s_axis_ready), 1);
        chk("mid_rst_win_val", 32'(o_win_valid),  0);
        chk("mid_rst_intr",    32'(intr),         0);
        tick(1'b0, 1'b1);
        chk("mid_rst_rd_en",   32'(o_lb_rd_en),   0);
        axis_resetn = 1'b1;
        n_intr = 0; n_str = 0;
        for (int c = 0; c < 600; c++) begin
            tick(1'b0, 1'b1);
            if (intr) n_intr++;
            if (o_lb_rd_en != 4'b0) n_str++;
        end
        chk("post_rst_no_intr",   32'(n_intr), 0);
        chk("post_rst_no_strobe", 32'(n_str),  0);
        chk("post_rst_rd_sel",    32'(o_rd_sel), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_sequencer.md
Name: line_buffer_sequencer

Overview:
- Control unit for the 3x3 filter front end.
- Steers incoming pixels into one of NUM_LB external line buffers (write pointer rotation).
- Once three full lines are buffered, issues W read strobes to three consecutive buffers to form 3-row windows, then raises an interrupt so the host supplies the next line.
- Sits between the AXI-stream-style pixel input and the line-buffer/MAC datapath inside the top-level filter.

Parameters:
- IMG_WIDTH, 512, pixels per line (W).
- NUM_LB, 4, number of line buffers; fixed at 4 (pointer logic is mod 4).
- CNT_W, 12, width of the buffered-pixel counter; must hold NUM_LB*IMG_WIDTH.

Ports:
- axis_clk, in, 1, single clock; all logic rising-edge.
- axis_resetn, in, 1, asynchronous active-low reset.
- i_datavalid, in, 1, input pixel valid this cycle.
- s_axis_ready, out, 1, input can be accepted.
- m_axis_ready, in, 1, downstream can take a window this cycle.
- o_lb_wr_en, out, NUM_LB, one-hot write enable to the line buffers.
- o_lb_rd_en, out, NUM_LB, read enables; three bits set while reading.
- o_rd_sel, out, 2, index of the buffer holding the top window row.
- o_win_valid, out, 1, window data valid; follows each read strobe by 1 cycle (buffer read latency is 1).
- intr, out, 1, one-cycle pulse: a line buffer has been freed.
- o_ovf, out, 1, sticky overflow flag.

Behaviour:
- Reset: all outputs 0 except s_axis_ready=1. All pointers, counters, state = 0/IDLE.
- Accept: acc = i_datavalid & s_axis_ready.
- s_axis_ready = (total_cnt < NUM_LB*W), combinational from the register.
- Overflow: i_datavalid while !s_axis_ready drops the pixel and sets o_ovf=1; o_ovf clears only on reset.
- Write enable: o_lb_wr_en = acc ? onehot(wr_ptr) : 0 (combinational).
- Write counter:
  - wr_cnt increments on acc.
  - At wr_cnt==W-1 with acc: wr_cnt←0, wr_ptr←wr_ptr+1 mod 4.
- Read strobe: rd = (state==RD) & m_axis_ready.
- o_lb_rd_en: bits rd_ptr, rd_ptr+1, rd_ptr+2 (mod 4) set when rd=1, else 0.
- o_rd_sel = rd_ptr (registered).
- total_cnt update per edge:
  - +1 on acc & !rd.
  - −1 on rd & !acc.
  - Unchanged when both or neither.
  - The −1 per read models consumption of the top row.
- FSM states: IDLE, RD.
  - IDLE→RD when total_cnt ≥ 3W (register value).
  - RD: rd_cnt increments on rd. On rd with rd_cnt==W-1: rd_cnt←0, rd_ptr←rd_ptr+1 mod 4, state←IDLE, intr=1 for exactly the following cycle.
  - Stalled cycles (m_axis_ready=0) hold rd_cnt; no strobe is issued.
- o_win_valid: register of rd, reset 0.
- Reset asserted mid-RD aborts immediately. No partial interrupt is issued after reset.
- Writes and reads proceed concurrently; the write pointer never overtakes reads because of the s_axis_ready gating.

Decomposition:
- Shared filter package holds: IMG_WIDTH and NUM_LB defaults, the FSM state enum {IDLE, RD}, and a mod-4 pointer-increment function.
- No sub-module is needed; the counter/pointer pair is small enough to live inline.

Test Plan:
- Reset check: hold axis_resetn=0, toggle inputs → all outputs 0, s_axis_ready=1, o_rd_sel=0.
- Three-line fill: send 1536 contiguous valid pixels with m_axis_ready=1 →
  - o_lb_wr_en = 0001, 0010, 0100 per 512-pixel line.
  - Read strobes begin 2 cycles after the 1536th pixel's cycle, with o_lb_rd_en=0111 for 512 cycles.
  - o_win_valid lags the strobes by 1 cycle.
  - intr is a single pulse the cycle after the last strobe; o_rd_sel becomes 1.
- Four-line fill with simultaneous read: send 2048 pixels back-to-back → s_axis_ready stays 1, intr pulses once, final total_cnt=1536, next rd_en=1110.
- Backpressure: in RD, toggle m_axis_ready every cycle → exactly 512 strobes, intr only after the 512th, o_win_valid count = 512.
- Overflow: hold m_axis_ready=0, send 2049 pixels → s_axis_ready drops after the 2048th, o_ovf=1, the 2049th pixel produces no wr_en, wr_ptr=0.
- Wrap and mid-op reset:
  - Stream 6 lines with reads enabled → o_rd_sel steps 0,1,2,3; wr_en returns to 0001 for line 5.
  - Assert reset at rd_cnt=200 → all state cleared, no intr pulse.
